tge_read_depacketizer: RTL and testbench

- Receive-side counterpart of the 10GbE write packetizer.
- Accepts 64-bit beats from the TGE core RX interface and filters frames by source IP/port and by length.
- Holds each frame in a commit/rollback buffer so that bad, short, long or overflowing frames vanish without trace.
- Emits accepted payload as 128-bit words, first 64-bit beat in dout[127:64], through a valid/ready stream toward downstream FRB processing.

---
 rtl/tge_rx_pkg.sv | 23 ++
 rtl/tge_read_depacketizer_if.sv | 35 +++
 rtl/tge_rx_frame_buffer.sv | 83 ++++++++
 rtl/tge_read_depacketizer.sv | 153 +++++++++++++++
 tb/tb_tge_read_depacketizer.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tge_rx_pkg.sv
// Shared definitions for the 10GbE receive depacketizer.
// Holds the RX beat / output word widths, the frame FSM state encoding and
// a drop-reason encoding that is available for debug taps.
package tge_rx_pkg;

  localparam int BEAT_W = 64;
  localparam int WORD_W = 2 * BEAT_W;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP
  } state_t;

  typedef enum logic [2:0] {
    FILTER,
    LENGTH,
    BADFRAME,
    OVERFLOW,
    OVERRUN
  } drop_reason_t;

endpackage

// File: rtl/tge_read_depacketizer_if.sv
// Signal bundle between the TGE core RX side, the depacketizer and the
// downstream payload consumer.
//   rx_*            : beat stream from the core plus its acknowledges
//   dout/dout_valid : 128-bit payload words toward downstream
//   dout_ready      : downstream accept
// master = environment (core + consumer), slave = depacketizer.
interface tge_read_depacketizer_if;
  import tge_rx_pkg::*;

  logic [BEAT_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_eof;
  logic              rx_bad_frame;
  logic              rx_overrun;
  logic [31:0]       rx_source_ip;
  logic [15:0]       rx_source_port;
  logic              rx_ack;
  logic              rx_overrun_ack;
  logic [WORD_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output rx_data, rx_valid, rx_eof, rx_bad_frame, rx_overrun,
           rx_source_ip, rx_source_port, dout_ready,
    input  rx_ack, rx_overrun_ack, dout, dout_valid
  );

  modport slave (
    input  rx_data, rx_valid, rx_eof, rx_bad_frame, rx_overrun,
           rx_source_ip, rx_source_port, dout_ready,
    output rx_ack, rx_overrun_ack, dout, dout_valid
  );

endinterface

// File: rtl/tge_rx_frame_buffer.sv
// Commit/rollback frame buffer: DEPTH x WORD_W simple dual-port RAM.
// Writes land at the speculative pointer wr_spec; only words below wr_commit
// are visible to the reader, so a rolled-back frame never reaches dout.
// Ports:
//   clk, rst (async, active-low)
//   wr_en/wr_data   : speculative word write
//   commit          : publish everything written so far, including this cycle
//   rollback        : discard uncommitted words (wins over wr_en)
//   full            : no free word for a write this cycle
//   dout/dout_valid/dout_ready : registered output stream
module tge_rx_frame_buffer #(
  parameter int WORD_W = 128,
  parameter int DEPTH  = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              commit,
  input  logic              rollback,
  output logic              full,
  output logic [WORD_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WORD_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_spec, wr_commit;
  logic [WORD_W-1:0] q_p1;
  logic              vld_p1;
  logic              avail, out_ld, q_adv, rd_en;

  // Extra pointer bit distinguishes full from empty.
  assign full   = (wr_spec - rd_ptr) == PW'(DEPTH);
  assign avail  = rd_ptr != wr_commit;
  assign out_ld = !dout_valid || dout_ready;
  assign q_adv  = !vld_p1 || out_ld;
  assign rd_en  = q_adv && avail;

  always_ff @(posedge clk) begin
    if (wr_en && !rollback) mem[wr_spec[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_spec   <= '0;
      wr_commit <= '0;
    end else begin
      if (rollback)   wr_spec <= wr_commit;
      else if (wr_en) wr_spec <= wr_spec + 1'b1;
      if (commit) wr_commit <= wr_spec + {{AW{1'b0}}, wr_en};
    end
  end

  // Stage p1: RAM read register
  always_ff @(posedge clk) begin
    if (rd_en) q_p1 <= mem[rd_ptr[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      vld_p1 <= 1'b0;
    end else begin
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (q_adv) vld_p1 <= avail;
    end
  end

  // Stage p2: output register, held until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (out_ld) begin
      dout_valid <= vld_p1;
      if (vld_p1) dout <= q_p1;
    end
  end

endmodule

// File: rtl/tge_read_depacketizer.sv
// 10GbE receive depacketizer. Filters incoming frames by source IP/port and
// by length, pairs 64-bit beats into 128-bit words (first beat in the upper
// half) and stores them speculatively; a frame becomes visible downstream
// only when it ends with exactly pkt_len beats and no error.
// Ports:
//   clk, rst (async, active-low)
//   rx        : interface bundle (RX beats, acks, payload stream)
//   pkt_len, config_src_ip, config_src_port, filter_en : per-frame config
//   fifo_full : one-cycle pulse when a frame is dropped for lack of space
//   pkt_count, drop_count : committed / discarded frame counters
module tge_read_depacketizer
  import tge_rx_pkg::*;
#(
  parameter int DOUT_WIDTH = 128,
  parameter int FIFO_DEPTH = 512
) (
  input  logic        clk,
  input  logic        rst,
  tge_read_depacketizer_if.slave rx,
  input  logic [31:0] pkt_len,
  input  logic [31:0] config_src_ip,
  input  logic [31:0] config_src_port,
  input  logic        filter_en,
  output logic        fifo_full,
  output logic [31:0] pkt_count,
  output logic [31:0] drop_count
);
  state_t            state, state_nx;
  logic [31:0]       beat_cnt, cnt_inc, len_p0;
  logic [BEAT_W-1:0] stage_p0;
  logic              len_ok, src_ok, buf_full;
  logic              first_ld, stage_ld, cnt_ld, wr_en, commit, rollback;
  logic              pkt_inc, drop_inc, ovf;
  logic              cfg_port_unused;

  assign rx.rx_ack         = rx.rx_valid;
  assign rx.rx_overrun_ack = rx.rx_overrun;
  assign cfg_port_unused   = ^config_src_port[31:16];

  // Config is only consulted on a frame's first beat; pkt_len is kept for RECV.
  assign len_ok  = !pkt_len[0] && (pkt_len >= 32'd2) && (pkt_len <= 32'(2 * FIFO_DEPTH));
  assign src_ok  = !filter_en || ((rx.rx_source_ip == config_src_ip) &&
                                  (rx.rx_source_port == config_src_port[15:0]));
  assign cnt_inc = beat_cnt + 32'd1;

  always_comb begin
    state_nx = state;
    first_ld = 1'b0;
    stage_ld = 1'b0;
    cnt_ld   = 1'b0;
    wr_en    = 1'b0;
    commit   = 1'b0;
    rollback = 1'b0;
    pkt_inc  = 1'b0;
    drop_inc = 1'b0;
    ovf      = 1'b0;
    case (state)
      IDLE: begin
        if (rx.rx_valid) begin
          if (src_ok && len_ok) first_ld = 1'b1;
          // A legal length is at least 2 beats, so eof here is always a drop.
          if (rx.rx_eof)                 drop_inc = 1'b1;
          else if (src_ok && len_ok)     state_nx = RECV;
          else                           state_nx = DROP;
        end
      end
      RECV: begin
        if (rx.rx_overrun) begin
          rollback = 1'b1;
          drop_inc = 1'b1;
          state_nx = IDLE;
        end else if (rx.rx_valid) begin
          cnt_ld = 1'b1;
          if (cnt_inc[0])    stage_ld = 1'b1;
          else if (buf_full) ovf      = 1'b1;
          else               wr_en    = 1'b1;
          if (ovf) begin
            rollback = 1'b1;
            if (rx.rx_eof) begin
              drop_inc = 1'b1;
              state_nx = IDLE;
            end else begin
              state_nx = DROP;
            end
          end else if (rx.rx_eof) begin
            state_nx = IDLE;
            if ((cnt_inc == len_p0) && !rx.rx_bad_frame) begin
              commit  = 1'b1;
              pkt_inc = 1'b1;
            end else begin
              rollback = 1'b1;
              drop_inc = 1'b1;
            end
          end else if (cnt_inc > len_p0) begin
            rollback = 1'b1;
            state_nx = DROP;
          end
        end
      end
      DROP: begin
        if (rx.rx_overrun || (rx.rx_valid && rx.rx_eof)) begin
          drop_inc = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      beat_cnt   <= '0;
      len_p0     <= '0;
      fifo_full  <= 1'b0;
      pkt_count  <= '0;
      drop_count <= '0;
    end else begin
      state     <= state_nx;
      fifo_full <= ovf;
      if (first_ld) begin
        beat_cnt <= 32'd1;
        len_p0   <= pkt_len;
      end else if (cnt_ld) begin
        beat_cnt <= cnt_inc;
      end
      if (pkt_inc)  pkt_count  <= pkt_count + 32'd1;
      if (drop_inc) drop_count <= drop_count + 32'd1;
    end
  end

  // Stage p0: first beat of each pair waits here for its partner
  always_ff @(posedge clk) begin
    if (first_ld || stage_ld) stage_p0 <= rx.rx_data;
  end

  tge_rx_frame_buffer #(
    .WORD_W (DOUT_WIDTH),
    .DEPTH  (FIFO_DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_data    ({stage_p0, rx.rx_data}),
    .commit     (commit),
    .rollback   (rollback),
    .full       (buf_full),
    .dout       (rx.dout),
    .dout_valid (rx.dout_valid),
    .dout_ready (rx.dout_ready)
  );

endmodule

// File: tb/tb_tge_read_depacketizer.sv
module tb_tge_read_depacketizer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pkt_len;
  logic [31:0] config_src_ip;
  logic [31:0] config_src_port;
  logic        filter_en;
  logic        fifo_full;
  logic [31:0] pkt_count;
  logic [31:0] drop_count;

  tge_read_depacketizer_if rxi();

  tge_read_depacketizer #(.DOUT_WIDTH(128), .FIFO_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .rx              (rxi),
    .pkt_len         (pkt_len),
    .config_src_ip   (config_src_ip),
    .config_src_port (config_src_port),
    .filter_en       (filter_en),
    .fifo_full       (fifo_full),
    .pkt_count       (pkt_count),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  logic [127:0] sb[$];
  int           exp_pkt = 0, exp_drop = 0, exp_ff = 0, ff_seen = 0;
  int           ready_pct = 100;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a word is transferred.
  always @(negedge clk) begin
    if (rst) begin
      logic [127:0] w;
      check("rx_ack", {127'd0, rxi.rx_ack}, {127'd0, rxi.rx_valid});
      check("rx_overrun_ack", {127'd0, rxi.rx_overrun_ack}, {127'd0, rxi.rx_overrun});
      if (rxi.dout_valid && rxi.dout_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_word: got %h with nothing expected", rxi.dout);
        end else begin
          w = sb.pop_front();
          check("dout", rxi.dout, w);
        end
      end
      if (fifo_full) ff_seen++;
    end
  end

  initial begin
    rxi.dout_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rxi.dout_ready = ($urandom_range(99) < ready_pct);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [63:0] d, input bit eof, input bit bf);
    rxi.rx_data      = d;
    rxi.rx_valid     = 1'b1;
    rxi.rx_eof       = eof;
    rxi.rx_bad_frame = bf;
    tick();
    rxi.rx_valid     = 1'b0;
    rxi.rx_eof       = 1'b0;
    rxi.rx_bad_frame = 1'b0;
  endtask

  // Reference model: a frame is accepted iff its length setting is legal, the
  // source matches (when filtering), the beat count equals that length, it is
  // not flagged bad, no overrun interrupts it, and it fits in the buffer.
  task automatic send_frame(input int nbeats, input logic [31:0] len, input logic [31:0] ip,
                            input logic [15:0] port, input bit bad_f, input bit chg_len,
                            input int ovr_at, input bit seq_data, input int gap_pct);
    logic [63:0] beats[$];
    bit          accept;
    int          words;
    for (int i = 0; i < nbeats; i++)
      beats.push_back(seq_data ? 64'(i) : {$urandom, $urandom});
    rxi.rx_source_ip   = ip;
    rxi.rx_source_port = port;
    pkt_len            = len;
    words  = nbeats / 2;
    accept = (len % 2 == 0) && (len >= 2) && (len <= 2 * DEPTH) &&
             (!filter_en || (ip == config_src_ip && port == config_src_port[15:0])) &&
             (nbeats == int'(len)) && !bad_f && (ovr_at < 0);
    if (accept && (sb.size() + words > DEPTH)) begin
      accept = 1'b0;
      exp_ff++;
    end
    for (int i = 0; i < nbeats; i++) begin
      if (i == ovr_at) begin
        rxi.rx_overrun = 1'b1;
        tick();
        rxi.rx_overrun = 1'b0;
        break;
      end
      while ($urandom_range(99) < gap_pct) tick();
      drive_beat(beats[i], i == nbeats - 1, bad_f && (i == nbeats - 1));
      if (i == 0 && chg_len) pkt_len = len ^ 32'd2;
    end
    if (accept) begin
      for (int k = 0; k < words; k++) sb.push_back({beats[2*k], beats[2*k+1]});
      exp_pkt++;
    end else begin
      exp_drop++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      tick();
      n++;
    end
    repeat (4) tick();
    check({name, "_drain"}, sb.size(), 0);
    check({name, "_pkt_count"}, pkt_count, exp_pkt);
    check({name, "_drop_count"}, drop_count, exp_drop);
  endtask

  initial begin
    logic [31:0] lens[9];
    int          len_i, nb, ovr;
    logic [31:0] ip;
    logic [15:0] port;
    lens = '{32'd2, 32'd4, 32'd6, 32'd8, 32'd8, 32'd8, 32'd7, 32'd0, 32'd40};

    rxi.rx_data = '0; rxi.rx_valid = 0; rxi.rx_eof = 0; rxi.rx_bad_frame = 0;
    rxi.rx_overrun = 0; rxi.rx_source_ip = 32'h0A000002; rxi.rx_source_port = 16'h1234;
    pkt_len = 32'd8; config_src_ip = 32'h0A000002; config_src_port = 32'hBEEF_1234;
    filter_en = 1'b0;

    repeat (3) tick();
    check("rst_dout_valid", {127'd0, rxi.dout_valid}, 0);
    check("rst_dout", rxi.dout, 0);
    rst = 1'b1;
    tick();
    check("reset_pkt_count", pkt_count, 0);
    check("reset_drop_count", drop_count, 0);
    check("reset_fifo_full", {127'd0, fifo_full}, 0);
    check("reset_dout_valid", {127'd0, rxi.dout_valid}, 0);

    // First-word latency: valid at the 2nd edge after the eof edge.
    send_frame(2, 2, 32'h0A000002, 16'h1234, 0, 0, -1, 1, 0);
    check("lat_e0", {127'd0, rxi.dout_valid}, 0);
    tick();
    check("lat_e1", {127'd0, rxi.dout_valid}, 0);
    tick();
    check("lat_e2", {127'd0, rxi.dout_valid}, 1);
    wait_drain("latency");

    // Three back-to-back 8-beat frames
    for (int f = 0; f < 3; f++) send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 1, 0);
    wait_drain("b2b");

    // Bad frame between two good ones
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    send_frame(8, 8, 32'h0A000002, 16'h1234, 1, 0, -1, 0, 0);
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    wait_drain("badframe");

    // Source filter, alternating IPs
    filter_en = 1'b1;
    for (int f = 0; f < 6; f++)
      send_frame(8, 8, (f % 2) ? 32'h0A000003 : 32'h0A000002, 16'h1234, 0, 0, -1, 0, 10);
    wait_drain("filter");
    filter_en = 1'b0;

    // Short and long frames, then a good one; also latch check on pkt_len
    send_frame(6, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    send_frame(10, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 1, -1, 0, 0);
    send_frame(7, 7, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    wait_drain("length");

    // Overflow: no draining, five 8-beat frames into a 16-word buffer
    ready_pct = 0;
    repeat (3) tick();
    for (int f = 0; f < 5; f++) send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 1, 0);
    repeat (3) tick();
    check("ovf_fifo_full_pulses", ff_seen, exp_ff);
    check("ovf_pkt_count", pkt_count, exp_pkt);
    check("ovf_drop_count", drop_count, exp_drop);
    check("ovf_pending_words", sb.size(), 16);
    ready_pct = 100;
    wait_drain("overflow");

    // Overrun mid-frame, then a clean frame
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, 3, 0, 0);
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    wait_drain("overrun");

    // Randomized frames against the model
    ready_pct = 70;
    for (int f = 0; f < 60; f++) begin
      int n = 0;
      while (sb.size() > 8 && n < 1000) begin
        tick();
        n++;
      end
      if (n >= 1000) begin
        total++;
        bad++;
        $display("FAIL rand_space_wait: %0d words pending, wanted at most 8", sb.size());
      end
      filter_en = $urandom_range(1);
      len_i = $urandom_range(8);
      if (lens[len_i] >= 1 && lens[len_i] <= 10 && $urandom_range(99) < 70) nb = int'(lens[len_i]);
      else nb = $urandom_range(1, 10);
      ip   = ($urandom_range(99) < 70) ? config_src_ip : 32'h0A000003;
      port = ($urandom_range(99) < 80) ? config_src_port[15:0] : 16'h4321;
      ovr  = (nb >= 2 && $urandom_range(99) < 10) ? $urandom_range(1, nb - 1) : -1;
      send_frame(nb, lens[len_i], ip, port, $urandom_range(99) < 10,
                 $urandom_range(99) < 20, ovr, 0, 20);
      repeat ($urandom_range(2)) tick();
    end
    ready_pct = 100;
    filter_en = 1'b0;
    wait_drain("random");
    check("total_fifo_full_pulses", ff_seen, exp_ff);

    // Asynchronous reset mid-frame with committed data pending
    ready_pct = 0;
    repeat (3) tick();
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 0, 0);
    repeat (4) tick();
    check("pre_rst_dout_valid", {127'd0, rxi.dout_valid}, 1);
    pkt_len = 32'd8;
    for (int i = 0; i < 3; i++) drive_beat({$urandom, $urandom}, 0, 0);
    #3 rst = 1'b0;
    #1;
    check("mid_rst_dout_valid", {127'd0, rxi.dout_valid}, 0);
    check("mid_rst_pkt_count", pkt_count, 0);
    check("mid_rst_drop_count", drop_count, 0);
    check("mid_rst_fifo_full", {127'd0, fifo_full}, 0);
    sb.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    tick();
    rst = 1'b1;
    repeat (4) tick();
    check("post_rst_dout_valid", {127'd0, rxi.dout_valid}, 0);
    ready_pct = 100;
    send_frame(8, 8, 32'h0A000002, 16'h1234, 0, 0, -1, 1, 0);
    wait_drain("rst_recover");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
